alu_reg_file: RTL and testbench
===============================

Name: alu_reg_file

Overview:
- Operand register file and carry/shift-out flag register directly upstream of the ALU in the R.O.E core.
- Supplies the ALU operands rs_i/rt_i and its carry-in ov_i.
- Captures the write-back result and the ALU carry-out ov_o on the clock edge.
- Owns all architectural data state the ALU reads, plus a debug read port for the bench.

Parameters:
- NUM_REGS, 8, number of 8-bit registers (power of 2, minimum 4).
- ADDR_W, $clog2(NUM_REGS), register address width.
- DATA_W, 8, register width; must equal the ALU operand width.

Ports:
- clk  input  1  core clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- hold_i  input  1  stall: blocks all register and flag updates this cycle.
- rs_addr_i  input  ADDR_W  read address, operand s.
- rt_addr_i  input  ADDR_W  read address, operand t.
- rs_o  output  DATA_W  operand s to ALU rs_i.
- rt_o  output  DATA_W  operand t to ALU rt_i.
- wr_en_i  input  1  register write enable.
- wr_addr_i  input  ADDR_W  write address.
- wr_data_i  input  DATA_W  write-back data (ALU result_o or memory load data).
- ov_we_i  input  1  flag write enable.
- ov_d_i  input  1  flag input, from ALU ov_o.
- ov_clr_i  input  1  synchronous flag clear.
- ov_o  output  1  flag to ALU ov_i.
- dbg_addr_i  input  ADDR_W  debug read address.
- dbg_data_o  output  DATA_W  debug read data.
- wr_count_o  output  16  count of committed register writes.

Behaviour:
- Reset: asynchronous and active-low; all registers, the ov flag and wr_count_o clear to 0 immediately on rst_n falling.
  - Asynchronous reads therefore drive rs_o = rt_o = dbg_data_o = 0 during reset.
  - Reset asserted mid-write discards that write.
- Reads: combinational, zero latency.
  - rs_o = regs[rs_addr_i], rt_o = regs[rt_addr_i], dbg_data_o = regs[dbg_addr_i].
- Writes: on rising clk, when wr_en_i && !hold_i, regs[wr_addr_i] <= wr_data_i.
  - The new value is visible on reads from the next cycle (no bypass unless the optional feature is enabled).
- Register 0 is writable; there is no hardwired-zero register.
- Flag update, on rising clk, first match in priority order:
  - hold_i: flag holds.
  - ov_clr_i: flag <= 0 (clear wins over ov_we_i).
  - ov_we_i: flag <= ov_d_i.
  - otherwise: flag holds.
- ov_o is the registered flag: the carry produced in cycle N is consumed by the ALU in cycle N+1. This makes multi-byte ADD/SUB and SLL/SRL chains work.
- wr_count_o increments on each committed register write.
  - Wraps 16'hFFFF -> 0.
  - Does not increment when hold_i is high.
- Simultaneous read and write of the same address: the read returns the old value this cycle.
- Out-of-range addresses cannot occur because NUM_REGS = 2^ADDR_W.
- There is no state machine; state is NUM_REGS x DATA_W + 1 flag bit + 16-bit counter.

Optional Feature:
- Macro: ALU_REG_FILE_BYPASS_EN.
- Defined:
  - rs_o/rt_o forward wr_data_i combinationally when wr_en_i && !hold_i && read address == wr_addr_i.
  - ov_o forwards ov_d_i when ov_we_i && !ov_clr_i && !hold_i.
  - The dbg port is never bypassed.
- Undefined: reads and ov_o reflect only committed state, as specified above.

Decomposition:
- Package definitions gets:
  - typedef logic [7:0] data_t;
  - localparams REG_NUM = 8 and REG_ADDR_W = 3;
  - typedef logic [REG_ADDR_W-1:0] reg_addr_t.
- One natural sub-module, ov_flag_reg: the flag register with its hold/clear/write priority and optional bypass.
- The register array and write counter stay in alu_reg_file.

Test Plan:
- Reset: pulse rst_n low with regs preloaded -> rs_o, rt_o, ov_o, dbg_data_o and wr_count_o all 0 asynchronously, before any clk edge.
- Write/read: write r3 = 8'hA5 then r5 = 8'h3C; read rs=3, rt=5 -> rs_o = 8'hA5, rt_o = 8'h3C; wr_count_o = 2.
- Same-cycle read/write: r2 = 8'h11; write r2 = 8'h22 while reading r2 -> rs_o = 8'h11 that cycle and 8'h22 next cycle (with ALU_REG_FILE_BYPASS_EN: 8'h22 the same cycle).
- Hold: hold_i = 1 with wr_en_i = 1, r1 = 8'hFF, ov_we_i = 1, ov_d_i = 1 -> r1 and ov_o unchanged, wr_count_o unchanged.
- Flag priority: ov_we_i = 1, ov_d_i = 1, ov_clr_i = 1 -> ov_o = 0 next cycle. Then ov_we_i = 1, ov_d_i = 1 alone -> ov_o = 1.
- Carry chain with the ALU attached: r0 = 8'hFF, r1 = 8'h01, ADD with ov_we -> result 8'h00 written, ov_o = 1. Next ADD of 8'h00 + 8'h00 -> 8'h01.

Source files
------------

// File: rtl/alu_reg_file_pkg.sv
// Shared types and sizing constants for the ALU operand register file.
// Importers: alu_reg_file, alu_reg_file_ov_flag_reg.
package alu_reg_file_pkg;

    localparam int unsigned REG_NUM    = 8;
    localparam int unsigned REG_ADDR_W = 3;

    typedef logic [7:0]            data_t;
    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/alu_reg_file_ov_flag_reg.sv
// Carry/shift-out flag register feeding the ALU carry-in; hold > clear > write priority.
// Optional combinational forwarding of the incoming flag when ALU_REG_FILE_BYPASS_EN is defined.
module alu_reg_file_ov_flag_reg (
    input  logic clk,
    input  logic rst_n,
    input  logic hold,
    input  logic clr,
    input  logic we,
    input  logic d,
    output logic q
);

    logic flag_q;
    logic flag_d;

    always_comb begin
        flag_d = flag_q;
        if (hold) begin
            flag_d = flag_q;
        end else if (clr) begin
            flag_d = 1'b0;
        end else if (we) begin
            flag_d = d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_q <= 1'b0;
        end else begin
            flag_q <= flag_d;
        end
    end

`ifdef ALU_REG_FILE_BYPASS_EN
    assign q = (we && !clr && !hold) ? d : flag_q;
`else
    assign q = flag_q;
`endif

endmodule

// File: rtl/alu_reg_file.sv
// Operand register file, carry flag and committed-write counter upstream of the ALU.
// Define ALU_REG_FILE_BYPASS_EN to forward same-cycle writes onto rs_o/rt_o and ov_o.
module alu_reg_file
    import alu_reg_file_pkg::*;
#(
    parameter int unsigned NUM_REGS = REG_NUM,
    parameter int unsigned ADDR_W   = $clog2(NUM_REGS),
    parameter int unsigned DATA_W   = $bits(data_t)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hold_i,
    input  logic [ADDR_W-1:0] rs_addr_i,
    input  logic [ADDR_W-1:0] rt_addr_i,
    output logic [DATA_W-1:0] rs_o,
    output logic [DATA_W-1:0] rt_o,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              ov_we_i,
    input  logic              ov_d_i,
    input  logic              ov_clr_i,
    output logic              ov_o,
    input  logic [ADDR_W-1:0] dbg_addr_i,
    output logic [DATA_W-1:0] dbg_data_o,
    output logic [15:0]       wr_count_o
);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [15:0]       wr_count_q;
    logic              wr_commit;

    assign wr_commit = wr_en_i && !hold_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_commit) begin
            regs_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Free-running wrap at 16'hFFFF is intended.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_count_q <= '0;
        end else if (wr_commit) begin
            wr_count_q <= wr_count_q + 16'd1;
        end
    end

    assign wr_count_o = wr_count_q;
    assign dbg_data_o = regs_q[dbg_addr_i];

`ifdef ALU_REG_FILE_BYPASS_EN
    assign rs_o = (wr_commit && (rs_addr_i == wr_addr_i)) ? wr_data_i : regs_q[rs_addr_i];
    assign rt_o = (wr_commit && (rt_addr_i == wr_addr_i)) ? wr_data_i : regs_q[rt_addr_i];
`else
    assign rs_o = regs_q[rs_addr_i];
    assign rt_o = regs_q[rt_addr_i];
`endif

    alu_reg_file_ov_flag_reg u_ov_flag (
        .clk   (clk),
        .rst_n (rst_n),
        .hold  (hold_i),
        .clr   (ov_clr_i),
        .we    (ov_we_i),
        .d     (ov_d_i),
        .q     (ov_o)
    );

endmodule

// File: tb/tb_alu_reg_file.sv
// Directed bench for alu_reg_file: expectations queued as stimulus is driven, then drained
// against the DUT outputs; the bench itself plays the ALU for the carry-chain step.
module tb_alu_reg_file;

    localparam int unsigned AW = 3;
    localparam int unsigned DW = 8;

    typedef enum int {SelRs, SelRt, SelOv, SelDbg, SelCnt} sel_e;

    typedef struct {
        string       tag;
        sel_e        sel;
        logic [31:0] exp;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic          hold_i;
    logic [AW-1:0] rs_addr_i;
    logic [AW-1:0] rt_addr_i;
    logic [DW-1:0] rs_o;
    logic [DW-1:0] rt_o;
    logic          wr_en_i;
    logic [AW-1:0] wr_addr_i;
    logic [DW-1:0] wr_data_i;
    logic          ov_we_i;
    logic          ov_d_i;
    logic          ov_clr_i;
    logic          ov_o;
    logic [AW-1:0] dbg_addr_i;
    logic [DW-1:0] dbg_data_o;
    logic [15:0]   wr_count_o;

    exp_t sb_q[$];
    int   total;
    int   bad;

    alu_reg_file dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .hold_i     (hold_i),
        .rs_addr_i  (rs_addr_i),
        .rt_addr_i  (rt_addr_i),
        .rs_o       (rs_o),
        .rt_o       (rt_o),
        .wr_en_i    (wr_en_i),
        .wr_addr_i  (wr_addr_i),
        .wr_data_i  (wr_data_i),
        .ov_we_i    (ov_we_i),
        .ov_d_i     (ov_d_i),
        .ov_clr_i   (ov_clr_i),
        .ov_o       (ov_o),
        .dbg_addr_i (dbg_addr_i),
        .dbg_data_o (dbg_data_o),
        .wr_count_o (wr_count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] observe(sel_e sel);
        case (sel)
            SelRs:   return {24'd0, rs_o};
            SelRt:   return {24'd0, rt_o};
            SelOv:   return {31'd0, ov_o};
            SelDbg:  return {24'd0, dbg_data_o};
            default: return {16'd0, wr_count_o};
        endcase
    endfunction

    task automatic expect_val(input string tag, input sel_e sel, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic drain();
        exp_t        e;
        logic [31:0] obs;
        while (sb_q.size() > 0) begin
            e   = sb_q.pop_front();
            obs = observe(e.sel);
            total++;
            assert (obs === e.exp) else begin
                bad++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.exp);
            end
        end
    endtask

    // Inputs change 1 time unit after the rising edge, well away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_en_i   = 1'b1;
        wr_addr_i = a;
        wr_data_i = d;
        tick();
        wr_en_i   = 1'b0;
    endtask

    // Bench-side ALU ADD: {carry, sum} = rs + rt + carry-in, written to wd.
    task automatic alu_add(input logic [AW-1:0] s, input logic [AW-1:0] t,
                           input logic [AW-1:0] wd);
        logic [DW:0] res;
        rs_addr_i = s;
        rt_addr_i = t;
        wr_en_i   = 1'b0;
        ov_we_i   = 1'b0;
        #1;
        res       = {1'b0, rs_o} + {1'b0, rt_o} + {{DW{1'b0}}, ov_o};
        wr_addr_i = wd;
        wr_data_i = res[DW-1:0];
        ov_d_i    = res[DW];
        wr_en_i   = 1'b1;
        ov_we_i   = 1'b1;
        tick();
        wr_en_i   = 1'b0;
        ov_we_i   = 1'b0;
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        rst_n      = 1'b0;
        hold_i     = 1'b0;
        rs_addr_i  = '0;
        rt_addr_i  = '0;
        wr_en_i    = 1'b0;
        wr_addr_i  = '0;
        wr_data_i  = '0;
        ov_we_i    = 1'b0;
        ov_d_i     = 1'b0;
        ov_clr_i   = 1'b0;
        dbg_addr_i = '0;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        expect_val("rst_ov", SelOv, 32'd0);
        expect_val("rst_cnt", SelCnt, 32'd0);
        expect_val("rst_dbg", SelDbg, 32'd0);
        drain();

        // Basic write then read on both operand ports.
        write_reg(3'd3, 8'hA5);
        write_reg(3'd5, 8'h3C);
        ov_we_i = 1'b1;
        ov_d_i  = 1'b1;
        tick();
        ov_we_i    = 1'b0;
        rs_addr_i  = 3'd3;
        rt_addr_i  = 3'd5;
        dbg_addr_i = 3'd3;
        #1;
        expect_val("wr_rs", SelRs, 32'hA5);
        expect_val("wr_rt", SelRt, 32'h3C);
        expect_val("wr_dbg", SelDbg, 32'hA5);
        expect_val("wr_cnt", SelCnt, 32'd2);
        expect_val("wr_ov", SelOv, 32'd1);
        drain();

        // Asynchronous reset with state loaded, checked before any clock edge.
        rst_n = 1'b0;
        #1;
        expect_val("arst_rs", SelRs, 32'd0);
        expect_val("arst_rt", SelRt, 32'd0);
        expect_val("arst_ov", SelOv, 32'd0);
        expect_val("arst_dbg", SelDbg, 32'd0);
        expect_val("arst_cnt", SelCnt, 32'd0);
        drain();
        rst_n = 1'b1;
        tick();

        // Same-cycle read and write of r2.
        write_reg(3'd2, 8'h11);
        rs_addr_i = 3'd2;
        wr_en_i   = 1'b1;
        wr_addr_i = 3'd2;
        wr_data_i = 8'h22;
        #1;
`ifdef ALU_REG_FILE_BYPASS_EN
        expect_val("rw_same", SelRs, 32'h22);
`else
        expect_val("rw_same", SelRs, 32'h11);
`endif
        drain();
        tick();
        wr_en_i = 1'b0;
        #1;
        expect_val("rw_next", SelRs, 32'h22);
        expect_val("rw_cnt", SelCnt, 32'd2);
        drain();

        // Hold blocks register, flag and counter updates.
        hold_i     = 1'b1;
        wr_en_i    = 1'b1;
        wr_addr_i  = 3'd1;
        wr_data_i  = 8'hFF;
        ov_we_i    = 1'b1;
        ov_d_i     = 1'b1;
        rs_addr_i  = 3'd1;
        dbg_addr_i = 3'd1;
        tick();
        expect_val("hold_rs", SelRs, 32'd0);
        expect_val("hold_dbg", SelDbg, 32'd0);
        expect_val("hold_ov", SelOv, 32'd0);
        expect_val("hold_cnt", SelCnt, 32'd2);
        drain();
        hold_i  = 1'b0;
        wr_en_i = 1'b0;
        ov_we_i = 1'b0;
        tick();

        // Clear beats write; then write alone sets; then clear alone resets.
        ov_we_i  = 1'b1;
        ov_d_i   = 1'b1;
        ov_clr_i = 1'b1;
        tick();
        expect_val("clr_wins", SelOv, 32'd0);
        drain();
        ov_clr_i = 1'b0;
        tick();
        ov_we_i = 1'b0;
        #1;
        expect_val("we_sets", SelOv, 32'd1);
        drain();
        ov_clr_i = 1'b1;
        tick();
        ov_clr_i = 1'b0;
        #1;
        expect_val("clr_alone", SelOv, 32'd0);
        drain();

        // Carry chain: FF + 01 -> 00 carry 1, then 00 + 00 + carry -> 01 carry 0.
        write_reg(3'd0, 8'hFF);
        write_reg(3'd1, 8'h01);
        alu_add(3'd0, 3'd1, 3'd2);
        dbg_addr_i = 3'd2;
        #1;
        expect_val("add0_res", SelDbg, 32'h00);
        expect_val("add0_cout", SelOv, 32'd1);
        drain();
        alu_add(3'd2, 3'd2, 3'd3);
        dbg_addr_i = 3'd3;
        #1;
        expect_val("add1_res", SelDbg, 32'h01);
        expect_val("add1_cout", SelOv, 32'd0);
        expect_val("chain_cnt", SelCnt, 32'd6);
        drain();

        // Counter wrap: 65530 more commits bring 6 back around to 0.
        wr_en_i   = 1'b1;
        wr_addr_i = 3'd7;
        wr_data_i = 8'h5A;
        for (int i = 0; i < 65529; i++) begin
            @(posedge clk);
        end
        #1;
        expect_val("cnt_max", SelCnt, 32'hFFFF);
        drain();
        tick();
        wr_en_i = 1'b0;
        #1;
        expect_val("cnt_wrap", SelCnt, 32'd0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
